prg_loader: RTL and testbench
=============================

Name: prg_loader

Overview:
- Sits between the HPS download interface (ioctl stream from hps_io) and the laser500 core's memory bus.
- Converts the byte stream of a "Load Program" (PRG, index 1) or "Load Bin" (BIN, index 2) download into addressed RAM writes.
- Buffers bytes in a small FIFO, because the core's RAM port can stall.
- Holds the Z80 while loading and reports the loaded address range when finished.

Parameters:
- FIFO_DEPTH, 8, entries in the write buffer; power of two, min 2.
- BIN_BASE, 16'h8995, load address for index-2 files.
- PTR_ADDR, 16'h83E9, first of two BASIC end-of-program pointer bytes (used only with the optional feature).

Ports:
- clk  in  1  14.7 MHz system clock (F14M).
- reset_n  in  1  asynchronous, active-low reset.
- ioctl_download  in  1  high for the whole download.
- ioctl_index  in  8  file type: 1 = PRG, 2 = BIN, others ignored.
- ioctl_wr  in  1  one-cycle strobe; byte valid on ioctl_data.
- ioctl_addr  in  25  byte offset within the file.
- ioctl_data  in  8  byte value.
- ioctl_wait  out  1  backpressure to hps_io; high while the FIFO is full.
- ram_addr  out  16  RAM write address.
- ram_dout  out  8  RAM write data.
- ram_wr  out  1  write request; held until acked.
- ram_ack  in  1  one-cycle acceptance of the current write.
- cpu_hold  out  1  high from download start until all writes are done.
- load_start  out  16  first RAM address written.
- load_end  out  16  last RAM address written + 1.
- done  out  1  one-cycle pulse when the load completes.

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE. Reset mid-load aborts immediately; no done pulse is issued.
- States: IDLE, HDR_LO, HDR_HI, DATA, DRAIN, PATCH_LO, PATCH_HI, FINISH.
- IDLE:
  - On the rising edge of ioctl_download with index 1, go to HDR_LO.
  - With index 2, set cur_addr = BIN_BASE, load_start = BIN_BASE, and go to DATA.
  - With any other index, stay in IDLE; cpu_hold stays 0 and strobes are ignored.
- HDR_LO / HDR_HI (PRG only): the first two strobes carry the little-endian load address. On the second strobe, set cur_addr and load_start and go to DATA. No RAM writes occur in these states.
- DATA:
  - Each strobe pushes {cur_addr, ioctl_data} into the FIFO, then cur_addr increments by 1, wrapping 16'hFFFF to 16'h0000.
  - ioctl_addr is informational only; ordering comes from the strobes.
  - On the falling edge of ioctl_download, go to DRAIN.
- FIFO behaviour:
  - ioctl_wait is registered and equals FIFO full, or full-minus-one when a push and no pop happen in the same cycle.
  - A strobe that arrives while full is dropped and sets sticky internal flag ovf. This is a bench error; the flag is cleared by reset.
  - A simultaneous push and pop is legal at any fill level.
- Drain side:
  - When the FIFO is not empty and ram_wr is low, present the head entry and raise ram_wr on the next cycle.
  - Pop on ram_ack, then drop ram_wr, giving at most one write per two cycles.
  - ram_addr and ram_dout are stable while ram_wr is high.
- DRAIN:
  - When the FIFO is empty and no write is pending, set load_end = cur_addr and go to PATCH_LO if the feature is enabled, otherwise to FINISH.
- FINISH: pulse done for 1 cycle, drop cpu_hold on the same cycle, return to IDLE.
- cpu_hold rises in the cycle after the download edge is detected and stays high continuously until FINISH.
- A download that ends during HDR_LO or HDR_HI (fewer than 2 bytes): go to FINISH, with load_start = load_end = 0 and no writes.
- A new rising edge of ioctl_download while not in IDLE is ignored. The FSM only arms from IDLE.

Optional Feature:
- Macro: LOADER_BASIC_PTR_EN.
- When defined and index = 1:
  - PATCH_LO writes load_end[7:0] to PTR_ADDR.
  - PATCH_HI writes load_end[15:8] to PTR_ADDR+1.
  - Both use the same ram_wr/ram_ack handshake; then go to FINISH. This lets BASIC RUN/LIST see the program.
- For index 2 the PATCH states are skipped even when the macro is defined.
- When not defined, the PATCH states and their logic are absent, and DRAIN goes straight to FINISH.

Test Plan:
- PRG with header 95 89 followed by 4 bytes AA BB CC DD, ram_ack one cycle after each ram_wr -> writes 8995=AA, 8996=BB, 8997=CC, 8998=DD; load_start=8995, load_end=8999; one done pulse; cpu_hold high throughout.
- BIN of 3 bytes 01 02 03 -> writes at BIN_BASE, +1, +2; no header consumed; load_end=BIN_BASE+3.
- ram_ack withheld for 40 cycles during a 20-byte burst with FIFO_DEPTH=8 -> ioctl_wait asserts once 8 entries are queued; no byte is lost or reordered; ovf stays 0; writes resume in order.
- PRG with header FE FF and 4 bytes -> writes at FFFE, FFFF, 0000, 0001; load_end=0002.
- reset_n pulled low after 2 of 10 data bytes -> all outputs 0 at once; no done pulse; after release, a fresh BIN load works normally.
- With LOADER_BASIC_PTR_EN defined: PRG load ending at 0x9000 -> two extra writes, 83E9=00 and 83EA=90, after the data writes and before done. With a BIN load -> no patch writes.

Source files
------------

// File: rtl/prg_loader.sv
// prg_loader: turns an hps_io PRG/BIN download into buffered, addressed RAM writes while holding the Z80.
// Optional LOADER_BASIC_PTR_EN: after a PRG load, patch the BASIC end-of-program pointer at PTR_ADDR.
module prg_loader #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [15:0] BIN_BASE   = 16'h8995,
    parameter logic [15:0] PTR_ADDR   = 16'h83E9
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    output logic        ioctl_wait,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_dout,
    output logic        ram_wr,
    input  logic        ram_ack,
    output logic        cpu_hold,
    output logic [15:0] load_start,
    output logic [15:0] load_end,
    output logic        done
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        HDR_LO,
        HDR_HI,
        DATA,
        DRAIN,
`ifdef LOADER_BASIC_PTR_EN
        PATCH_LO,
        PATCH_HI,
`endif
        FINISH
    } state_t;

    state_t        state, state_next;
    logic          dl_q;
    logic [7:0]    hdr_lo;
    logic [15:0]   cur_addr;
    logic [23:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_next;
    logic          ovf;
    logic          rise, arm_prg, arm_bin;
    logic          full, empty, push_req, push, fifo_pop, drain_idle, hdr_abort;
    logic [23:0]   head;
`ifdef LOADER_BASIC_PTR_EN
    logic          is_prg;
    logic          patching;
`endif

    assign rise       = ioctl_download & ~dl_q;
    assign arm_prg    = (state == IDLE) && rise && (ioctl_index == 8'd1);
    assign arm_bin    = (state == IDLE) && rise && (ioctl_index == 8'd2);
    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign push_req   = (state == DATA) && ioctl_wr;
    assign drain_idle = empty && !ram_wr;
    assign head       = mem[rd_ptr];
    assign hdr_abort  = ((state == HDR_LO) || (state == HDR_HI)) && !ioctl_wr && !ioctl_download;

`ifdef LOADER_BASIC_PTR_EN
    assign patching = (state == PATCH_LO) || (state == PATCH_HI);
    // Patch writes share the RAM port but never come from the FIFO.
    assign fifo_pop = ram_wr && ram_ack && !patching;
`else
    assign fifo_pop = ram_wr && ram_ack;
`endif
    // A push is still accepted when full if the head leaves in the same cycle.
    assign push       = push_req && (!full || fifo_pop);
    assign count_next = count + (AW + 1)'(push) - (AW + 1)'(fifo_pop);

    logic unused_ok;
    assign unused_ok = &{1'b0, ioctl_addr, ovf, PTR_ADDR};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        cpu_hold   = 1'b1;
        case (state)
            IDLE: begin
                cpu_hold = 1'b0;
                if (arm_prg)      state_next = HDR_LO;
                else if (arm_bin) state_next = DATA;
            end
            HDR_LO: begin
                if (ioctl_wr)             state_next = HDR_HI;
                else if (!ioctl_download) state_next = FINISH;
            end
            HDR_HI: begin
                if (ioctl_wr)             state_next = DATA;
                else if (!ioctl_download) state_next = FINISH;
            end
            DATA: begin
                if (!ioctl_download) state_next = DRAIN;
            end
            DRAIN: begin
                if (drain_idle) begin
`ifdef LOADER_BASIC_PTR_EN
                    state_next = is_prg ? PATCH_LO : FINISH;
`else
                    state_next = FINISH;
`endif
                end
            end
`ifdef LOADER_BASIC_PTR_EN
            PATCH_LO: begin
                if (ram_wr && ram_ack) state_next = PATCH_HI;
            end
            PATCH_HI: begin
                if (ram_wr && ram_ack) state_next = FINISH;
            end
`endif
            FINISH: begin
                done       = 1'b1;
                cpu_hold   = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cur_addr, ioctl_data};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dl_q       <= 1'b0;
            hdr_lo     <= '0;
            cur_addr   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ovf        <= 1'b0;
            ioctl_wait <= 1'b0;
            ram_addr   <= '0;
            ram_dout   <= '0;
            ram_wr     <= 1'b0;
            load_start <= '0;
            load_end   <= '0;
`ifdef LOADER_BASIC_PTR_EN
            is_prg     <= 1'b0;
`endif
        end else begin
            dl_q       <= ioctl_download;
            count      <= count_next;
            ioctl_wait <= (count_next == FULL_CNT);

            if (push_req && full && !fifo_pop) ovf <= 1'b1;

`ifdef LOADER_BASIC_PTR_EN
            if (arm_prg)      is_prg <= 1'b1;
            else if (arm_bin) is_prg <= 1'b0;
`endif
            if (arm_bin) begin
                cur_addr   <= BIN_BASE;
                load_start <= BIN_BASE;
            end
            if ((state == HDR_LO) && ioctl_wr) hdr_lo <= ioctl_data;
            if ((state == HDR_HI) && ioctl_wr) begin
                cur_addr   <= {ioctl_data, hdr_lo};
                load_start <= {ioctl_data, hdr_lo};
            end
            if (hdr_abort) begin
                load_start <= '0;
                load_end   <= '0;
            end
            if (push) begin
                wr_ptr   <= wr_ptr + AW'(1);
                cur_addr <= cur_addr + 16'd1;
            end
            if (fifo_pop) rd_ptr <= rd_ptr + AW'(1);
            if ((state == DRAIN) && drain_idle) load_end <= cur_addr;

            if (ram_wr) begin
                if (ram_ack) ram_wr <= 1'b0;
            end else if (!empty) begin
                ram_wr   <= 1'b1;
                ram_addr <= head[23:8];
                ram_dout <= head[7:0];
            end
`ifdef LOADER_BASIC_PTR_EN
            else if (state == PATCH_LO) begin
                ram_wr   <= 1'b1;
                ram_addr <= PTR_ADDR;
                ram_dout <= load_end[7:0];
            end else if (state == PATCH_HI) begin
                ram_wr   <= 1'b1;
                ram_addr <= PTR_ADDR + 16'd1;
                ram_dout <= load_end[15:8];
            end
`endif
        end
    end
endmodule

// File: tb/tb_prg_loader.sv
// Scoreboard bench for prg_loader: stimulus queues expected RAM writes, a monitor checks each accepted write.
module tb_prg_loader;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = '0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic        ioctl_wait;
    logic [15:0] ram_addr;
    logic [7:0]  ram_dout;
    logic        ram_wr;
    logic        ram_ack = 1'b0;
    logic        cpu_hold;
    logic [15:0] load_start;
    logic [15:0] load_end;
    logic        done;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned done_cnt = 0;
    int unsigned exp_done = 0;
    logic        stall = 1'b0;
    logic [23:0] sb [$];

    prg_loader #(.FIFO_DEPTH(8), .BIN_BASE(16'h8995), .PTR_ADDR(16'h83E9)) dut (
        .clk(clk), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wait(ioctl_wait),
        .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_ack(ram_ack),
        .cpu_hold(cpu_hold), .load_start(load_start), .load_end(load_end), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, want);
        end
    endtask

    // RAM responder: ack one cycle after ram_wr rises, unless stalled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            ram_ack = ram_wr && !ram_ack && !stall;
        end
    end

    // Monitor: the cycle where ram_wr and ram_ack are both high is the accepted write.
    initial begin
        logic [23:0] e;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (reset_n && ram_wr && ram_ack) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write got=%h:%h expected=none", ram_addr, ram_dout);
                end else begin
                    e = sb.pop_front();
                    check("wr_addr", {16'h0, ram_addr}, {16'h0, e[23:8]});
                    check("wr_data", {24'h0, ram_dout}, {24'h0, e[7:0]});
                    check("wr_hold", {31'h0, cpu_hold}, 32'h1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic expect_wr(input logic [15:0] a, input logic [7:0] d);
        sb.push_back({a, d});
    endtask

    task automatic start_dl(input logic [7:0] idx);
        ioctl_index = idx;
        ioctl_download = 1'b1;
        ioctl_addr = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] d);
        int unsigned guard = 0;
        while (ioctl_wait && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (ioctl_wait) check("wait_timeout", {31'h0, ioctl_wait}, 32'h0);
        ioctl_wr = 1'b1;
        ioctl_data = d;
        @(posedge clk);
        #1;
        ioctl_wr = 1'b0;
        ioctl_data = '0;
        ioctl_addr = ioctl_addr + 25'd1;
    endtask

    task automatic finish_load(input string name, input logic [15:0] s, input logic [15:0] e);
        int unsigned n = 0;
        ioctl_download = 1'b0;
        exp_done++;
        while (done !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, {31'h0, done}, 32'h1);
        check({name, "_hold_drop"}, {31'h0, cpu_hold}, 32'h0);
        @(posedge clk);
        #1;
        check({name, "_start"}, {16'h0, load_start}, {16'h0, s});
        check({name, "_end"}, {16'h0, load_end}, {16'h0, e});
        check({name, "_pending"}, sb.size(), 32'h0);
        check({name, "_done_cnt"}, done_cnt, exp_done);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr", {31'h0, ram_wr}, 32'h0);
        check("rst_hold", {31'h0, cpu_hold}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_wait", {31'h0, ioctl_wait}, 32'h0);
        check("rst_range", {load_start, load_end}, 32'h0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // PRG: header 95 89, four data bytes
        start_dl(8'd1);
        check("prg_hold_rise", {31'h0, cpu_hold}, 32'h1);
        strobe(8'h95);
        strobe(8'h89);
        expect_wr(16'h8995, 8'hAA); strobe(8'hAA);
        expect_wr(16'h8996, 8'hBB); strobe(8'hBB);
        expect_wr(16'h8997, 8'hCC); strobe(8'hCC);
        expect_wr(16'h8998, 8'hDD); strobe(8'hDD);
`ifdef LOADER_BASIC_PTR_EN
        expect_wr(16'h83E9, 8'h99);
        expect_wr(16'h83EA, 8'h89);
`endif
        finish_load("prg", 16'h8995, 16'h8999);

        // BIN: no header, loads at BIN_BASE
        start_dl(8'd2);
        expect_wr(16'h8995, 8'h01); strobe(8'h01);
        expect_wr(16'h8996, 8'h02); strobe(8'h02);
        expect_wr(16'h8997, 8'h03); strobe(8'h03);
        finish_load("bin", 16'h8995, 16'h8998);

        // Backpressure: RAM stalled for 40 cycles during a 20-byte burst
        stall = 1'b1;
        start_dl(8'd2);
        fork
            begin
                repeat (40) @(posedge clk);
                #1;
                stall = 1'b0;
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    expect_wr(16'h8995 + 16'(i), 8'h40 + 8'(i));
                    strobe(8'h40 + 8'(i));
                    if (i == 6) check("wait_not_full", {31'h0, ioctl_wait}, 32'h0);
                    if (i == 7) check("wait_full", {31'h0, ioctl_wait}, 32'h1);
                end
            end
        join
        check("ovf_clear", {31'h0, dut.ovf}, 32'h0);
        finish_load("burst", 16'h8995, 16'h89A9);

        // PRG wrapping past FFFF
        start_dl(8'd1);
        strobe(8'hFE);
        strobe(8'hFF);
        expect_wr(16'hFFFE, 8'h11); strobe(8'h11);
        expect_wr(16'hFFFF, 8'h22); strobe(8'h22);
        expect_wr(16'h0000, 8'h33); strobe(8'h33);
        expect_wr(16'h0001, 8'h44); strobe(8'h44);
`ifdef LOADER_BASIC_PTR_EN
        expect_wr(16'h83E9, 8'h02);
        expect_wr(16'h83EA, 8'h00);
`endif
        finish_load("wrap", 16'hFFFE, 16'h0002);

        // PRG ending at 9000
        start_dl(8'd1);
        strobe(8'hFC);
        strobe(8'h8F);
        expect_wr(16'h8FFC, 8'h05); strobe(8'h05);
        expect_wr(16'h8FFD, 8'h06); strobe(8'h06);
        expect_wr(16'h8FFE, 8'h07); strobe(8'h07);
        expect_wr(16'h8FFF, 8'h08); strobe(8'h08);
`ifdef LOADER_BASIC_PTR_EN
        expect_wr(16'h83E9, 8'h00);
        expect_wr(16'h83EA, 8'h90);
`endif
        finish_load("ptr", 16'h8FFC, 16'h9000);

        // Download ends after one header byte
        start_dl(8'd1);
        strobe(8'h12);
        finish_load("short", 16'h0000, 16'h0000);

        // Unknown index is ignored entirely
        start_dl(8'd3);
        check("idx3_hold", {31'h0, cpu_hold}, 32'h0);
        strobe(8'h77);
        strobe(8'h78);
        ioctl_download = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("idx3_hold_after", {31'h0, cpu_hold}, 32'h0);
        check("idx3_done_cnt", done_cnt, exp_done);

        // Reset mid-load with a write pending
        stall = 1'b1;
        start_dl(8'd2);
        strobe(8'hA1);
        strobe(8'hA2);
        check("pre_rst_wr", {31'h0, ram_wr}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("abort_wr", {31'h0, ram_wr}, 32'h0);
        check("abort_hold", {31'h0, cpu_hold}, 32'h0);
        check("abort_bus", {ram_addr, 8'h0, ram_dout}, 32'h0);
        check("abort_range", {load_start, load_end}, 32'h0);
        check("abort_wait_done", {30'h0, ioctl_wait, done}, 32'h0);
        ioctl_download = 1'b0;
        stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("abort_done_cnt", done_cnt, exp_done);

        start_dl(8'd2);
        expect_wr(16'h8995, 8'h5A); strobe(8'h5A);
        expect_wr(16'h8996, 8'hA5); strobe(8'hA5);
        finish_load("rebin", 16'h8995, 16'h8997);

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
